// File: rtl/ahb_lite_pkg.sv
// Shared constants, controller state type and the Collatz step rule.
package ahb_lite_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_OPERAND = 8'h00;
    localparam logic [ADDR_W-1:0] ADDR_RESULT  = 8'h01;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 8'h02;

    typedef enum logic [2:0] {
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_DATA,
        DONE
    } ctrl_state_t;

    // All arithmetic wraps at DATA_W bits.
    function automatic logic [DATA_W-1:0] collatz_next(
        input logic [DATA_W-1:0] n
    );
        logic [DATA_W-1:0] odd;
        odd = (n << 1) + n + DATA_W'(1);
        return n[0] ? odd : (n >> 1);
    endfunction

endpackage

// File: rtl/ahb_lite_peripheral.sv
// Collatz step engine slave: OPERAND/RESULT/STATUS registers on the bus.
// Stalls RESULT reads and OPERAND writes while a computation is running.
module ahb_lite_peripheral
    import ahb_lite_pkg::*;
#(
    parameter int COMPUTE_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write,
    input  logic              trans,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              readyout,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(COMPUTE_CYCLES);

    logic              dp_valid;
    logic              dp_write;
    logic [ADDR_W-1:0] dp_addr;
    logic              busy;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] result;
    logic              op_hit;
    logic              res_hit;
    logic              sts_hit;
    logic              wr_done;

    always_comb begin
        op_hit   = dp_valid && dp_write && (dp_addr == ADDR_OPERAND);
        res_hit  = dp_valid && !dp_write && (dp_addr == ADDR_RESULT);
        sts_hit  = dp_valid && !dp_write && (dp_addr == ADDR_STATUS);
        readyout = !(busy && (op_hit || res_hit));
        wr_done  = op_hit && readyout;
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            res_hit: rdata = result;
            sts_hit: rdata = {{(DATA_W-1){1'b0}}, busy};
            default: rdata = '0;
        endcase
    end

    // Data-phase context is captured whenever the slave is ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else if (readyout) begin
            dp_valid <= trans;
            dp_write <= write;
            dp_addr  <= waddr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            cnt     <= '0;
            operand <= '0;
            result  <= '0;
        end else if (wr_done) begin
            operand <= wdata;
            busy    <= 1'b1;
            cnt     <= CNT_LOAD;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                busy   <= 1'b0;
                result <= collatz_next(operand);
            end
        end
    end

endmodule

// File: rtl/ahb_lite_controller.sv
// Bus master walking the Collatz sequence from VALUE to 1 via the step engine.
// Optional step counter output enabled by AHB_LITE_STEP_COUNT_EN.
module ahb_lite_controller
    import ahb_lite_pkg::*;
#(
    parameter logic [DATA_W-1:0] VALUE = 8'd7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              readyout,
    input  logic [DATA_W-1:0] rdata,
    output logic              write,
    output logic              trans,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] value
`ifdef AHB_LITE_STEP_COUNT_EN
    ,
    output logic [7:0]        steps
`endif
);

    localparam ctrl_state_t START = (VALUE == 8'd1) ? DONE : WR_ADDR;

    ctrl_state_t       state;
    ctrl_state_t       next_state;
    logic [DATA_W-1:0] value_next;
    logic              rd_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= START;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        value_next = value;
        rd_done    = 1'b0;
        unique case (state)
            WR_ADDR: if (trans && readyout) next_state = WR_DATA;
            WR_DATA: if (readyout) next_state = RD_ADDR;
            RD_ADDR: if (trans && readyout) next_state = RD_DATA;
            RD_DATA: begin
                if (readyout) begin
                    rd_done    = 1'b1;
                    value_next = rdata;
                    next_state = (rdata == 8'd1) ? DONE : WR_ADDR;
                end
            end
            DONE:    next_state = DONE;
            default: next_state = START;
        endcase
    end

    // Bus outputs are registered from the next state so reset holds them at 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trans <= 1'b0;
            write <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            value <= VALUE;
        end else begin
            value <= value_next;
            trans <= (next_state == WR_ADDR) || (next_state == RD_ADDR);
            write <= (next_state == WR_ADDR);
            waddr <= (next_state == RD_ADDR) ? ADDR_RESULT : ADDR_OPERAND;
            if (next_state == WR_ADDR) wdata <= value_next;
        end
    end

`ifdef AHB_LITE_STEP_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            steps <= '0;
        end else if (rd_done && (steps != 8'hff)) begin
            steps <= steps + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_lite_controller.sv
// Bench: controller+engine systems (VALUE 7 and 1) and a standalone engine.
// Randomized engine operands are checked against a Collatz reference model.
module tb_ahb_lite_controller;

    logic clock = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    logic       s_ready, s_write, s_trans;
    logic [7:0] s_rdata, s_waddr, s_wdata, s_value;
    logic       c_ready, c_write, c_trans;
    logic [7:0] c_rdata, c_waddr, c_wdata, c_value;
    logic       p_ready;
    logic [7:0] p_rdata;
    logic       p_write = 1'b0;
    logic       p_trans = 1'b0;
    logic [7:0] p_waddr = 8'h00;
    logic [7:0] p_wdata = 8'h00;
`ifdef AHB_LITE_STEP_COUNT_EN
    logic [7:0] s_steps, c_steps;
`endif

    ahb_lite_controller u_ctrl (
        .clock(clock), .reset_n(reset_n),
        .readyout(s_ready), .rdata(s_rdata),
        .write(s_write), .trans(s_trans),
        .waddr(s_waddr), .wdata(s_wdata), .value(s_value)
`ifdef AHB_LITE_STEP_COUNT_EN
        , .steps(s_steps)
`endif
    );

    ahb_lite_peripheral u_per (
        .clock(clock), .reset_n(reset_n),
        .write(s_write), .trans(s_trans),
        .waddr(s_waddr), .wdata(s_wdata),
        .readyout(s_ready), .rdata(s_rdata)
    );

    ahb_lite_controller #(.VALUE(8'd1)) u_ctrl1 (
        .clock(clock), .reset_n(reset_n),
        .readyout(c_ready), .rdata(c_rdata),
        .write(c_write), .trans(c_trans),
        .waddr(c_waddr), .wdata(c_wdata), .value(c_value)
`ifdef AHB_LITE_STEP_COUNT_EN
        , .steps(c_steps)
`endif
    );

    ahb_lite_peripheral u_per1 (
        .clock(clock), .reset_n(reset_n),
        .write(c_write), .trans(c_trans),
        .waddr(c_waddr), .wdata(c_wdata),
        .readyout(c_ready), .rdata(c_rdata)
    );

    ahb_lite_peripheral u_pa (
        .clock(clock), .reset_n(reset_n),
        .write(p_write), .trans(p_trans),
        .waddr(p_waddr), .wdata(p_wdata),
        .readyout(p_ready), .rdata(p_rdata)
    );

    int n_pass = 0;
    int n_checks = 0;
    bit c_trans_seen = 1'b0;

    always @(negedge clock) if (c_trans === 1'b1) c_trans_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int ref_next(input int n);
        return (n % 2 == 0) ? n / 2 : (3 * n + 1) % 256;
    endfunction

    task automatic run_to_one(output int cyc, output int chg);
        int prev;
        prev = int'(s_value);
        cyc = 0;
        chg = 0;
        while (s_value !== 8'd1 && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (int'(s_value) != prev) begin
                chk("seq_step", s_value, ref_next(prev));
                chg++;
                prev = int'(s_value);
            end
        end
    endtask

    task automatic xfer(input logic wr, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] rd,
                        output int stalls);
        p_trans = 1'b1;
        p_write = wr;
        p_waddr = a;
        p_wdata = d;
        @(negedge clock);
        p_trans = 1'b0;
        p_write = 1'b0;
        stalls = 0;
        while (p_ready !== 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clock);
        end
        chk("dphase_bound", stalls < 40, 1);
        rd = p_rdata;
        @(negedge clock);
    endtask

    initial begin
        int cyc, chg, st, gap, rdn, guard, op, hi;
        logic [7:0] rd;

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_trans", s_trans, 0);
        chk("rst_write", s_write, 0);
        chk("rst_waddr", s_waddr, 0);
        chk("rst_wdata", s_wdata, 0);
        chk("rst_value", s_value, 7);
        chk("rst_p_ready", p_ready, 1);
        chk("rst_p_rdata", p_rdata, 0);
`ifdef AHB_LITE_STEP_COUNT_EN
        chk("rst_steps", s_steps, 0);
`endif

        reset_n = 1'b1;
        run_to_one(cyc, chg);
        chk("reach_one_lt128", cyc < 128, 1);
        chk("seq_changes", chg, 16);
        chk("final_value", s_value, 1);
        hi = 0;
        repeat (20) begin
            @(negedge clock);
            if (s_trans !== 1'b0) hi++;
        end
        chk("done_trans_idle", hi, 0);
        chk("done_value_held", s_value, 1);
`ifdef AHB_LITE_STEP_COUNT_EN
        chk("steps_16", s_steps, 16);
`endif
        chk("v1_trans_never", c_trans_seen, 0);
        chk("v1_value", c_value, 1);

        xfer(1'b1, 8'h00, 8'd6, rd, st);
        xfer(1'b0, 8'h01, 8'h00, rd, st);
        chk("res6_stall_min", st >= 1, 1);
        chk("res6_stall_max", st <= 2, 1);
        chk("res6_data", rd, 3);

        xfer(1'b1, 8'h00, 8'd6, rd, st);
        xfer(1'b0, 8'h02, 8'h00, rd, st);
        chk("status_busy", rd, 1);
        chk("status_nostall", st, 0);
        repeat (3) @(negedge clock);
        xfer(1'b0, 8'h02, 8'h00, rd, st);
        chk("status_idle", rd, 0);

        xfer(1'b1, 8'h00, 8'd171, rd, st);
        xfer(1'b0, 8'h01, 8'h00, rd, st);
        chk("ovf_171", rd, 2);
        xfer(1'b1, 8'h00, 8'd128, rd, st);
        xfer(1'b0, 8'h01, 8'h00, rd, st);
        chk("res_128", rd, 64);

        xfer(1'b0, 8'h10, 8'h00, rd, st);
        chk("unmapped_rd", rd, 0);
        chk("unmapped_rd_nostall", st, 0);
        xfer(1'b1, 8'h10, 8'h55, rd, st);
        chk("unmapped_wr_nostall", st, 0);
        xfer(1'b0, 8'h01, 8'h00, rd, st);
        chk("unmapped_wr_keeps", rd, 64);

        xfer(1'b1, 8'h00, 8'd9, rd, st);
        xfer(1'b1, 8'h00, 8'd10, rd, st);
        chk("busy_write_stalls", st >= 1, 1);
        xfer(1'b0, 8'h01, 8'h00, rd, st);
        chk("busy_write_data", rd, 5);

        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 3));
            xfer(1'b1, 8'h00, 8'(op), rd, st);
            repeat (gap) @(negedge clock);
            xfer(1'b0, 8'h01, 8'h00, rd, st);
            chk("rand_result", rd, ref_next(op));
            if (gap >= 2) chk("rand_nostall", st, 0);
            else          chk("rand_stall_le2", st <= 2, 1);
        end

        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        rdn = 0;
        guard = 0;
        while (rdn < 3 && guard < 200) begin
            @(negedge clock);
            guard++;
            if (s_trans === 1'b1 && s_write === 1'b0) rdn++;
        end
        chk("mid_reach_rd3", rdn, 3);
        @(negedge clock);
        chk("mid_rd_stalled", s_ready, 0);
        chk("mid_value", s_value, 11);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_trans", s_trans, 0);
        chk("mid_rst_write", s_write, 0);
        chk("mid_rst_waddr", s_waddr, 0);
        chk("mid_rst_wdata", s_wdata, 0);
        chk("mid_rst_value", s_value, 7);
        chk("mid_rst_ready", s_ready, 1);
        chk("mid_rst_rdata", s_rdata, 0);
`ifdef AHB_LITE_STEP_COUNT_EN
        chk("mid_rst_steps", s_steps, 0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        run_to_one(cyc, chg);
        chk("restart_lt128", cyc < 128, 1);
        chk("restart_changes", chg, 16);
        chk("restart_final", s_value, 1);
`ifdef AHB_LITE_STEP_COUNT_EN
        chk("restart_steps", s_steps, 16);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
